// File: rtl/pipe_pkg.sv
// Shared encodings for the two-stage pipeline sequencer.
// Func codes, sequencer states and ALU selects.
package pipe_pkg;

  typedef enum logic [1:0] {
    FN_LI   = 2'b00,
    FN_ADD  = 2'b01,
    FN_NOP  = 2'b10,
    FN_HALT = 2'b11
  } func_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  localparam logic ALU_IMM = 1'b0;
  localparam logic ALU_ADD = 1'b1;

  function automatic logic fn_writes(
    input logic [1:0] f
  );
    return (f == FN_LI) || (f == FN_ADD);
  endfunction

endpackage

// File: rtl/pipe_sequencer_hazard_unit.sv
// RAW detection between ID and WB.
// Either forwards or reports a hazard for the sequencer to stall on.
module hazard_unit
  import pipe_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic       id_valid,
  input  logic [1:0] func_id,
  input  logic [2:0] rdst_id,
  input  logic [2:0] rsrc_id,
  input  logic       wb_valid,
  input  logic       wb_wr,
  input  logic [2:0] rdst_wb,
  output logic       haz_a,
  output logic       haz_b,
  output logic       fwd_a,
  output logic       fwd_b
);

  logic wb_hit;

  assign wb_hit = wb_valid & wb_wr;

  assign haz_a = id_valid & fn_writes(func_id)
               & wb_hit & (rdst_wb == rdst_id);

  assign haz_b = id_valid & (func_id == FN_ADD)
               & wb_hit & (rdst_wb == rsrc_id);

  if (FWD_EN) begin : g_fwd
    assign fwd_a = haz_a;
    assign fwd_b = haz_b;
  end else begin : g_nofwd
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
  end

endmodule

// File: rtl/pipe_sequencer.sv
// Run control, stage valids, enables and retire count
// for the 8-bit two-stage pipeline.
module pipe_sequencer
  import pipe_pkg::*;
#(
  parameter int unsigned RCNT_W = 16,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              hold,
  input  logic [1:0]        func_id,
  input  logic [2:0]        rdst_id,
  input  logic [2:0]        rsrc_id,
  input  logic [2:0]        rdst_wb,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idwb_en,
  output logic              alu_control,
  output logic              write,
  output logic              fwd_a,
  output logic              fwd_b,
  output logic              halted,
  output logic [RCNT_W-1:0] retire_cnt
);

  state_e            state_q, state_d;
  logic              id_valid_q, id_valid_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_wr_q, wb_wr_d;
  logic              wb_alu_q, wb_alu_d;
  logic [RCNT_W-1:0] retire_q, retire_d;
  logic [1:0]        ret_n;
  logic              haz_a, haz_b;
  logic              stall, halt_id;

  hazard_unit #(
    .FWD_EN (FWD_EN)
  ) u_haz (
    .id_valid (id_valid_q),
    .func_id  (func_id),
    .rdst_id  (rdst_id),
    .rsrc_id  (rsrc_id),
    .wb_valid (wb_valid_q),
    .wb_wr    (wb_wr_q),
    .rdst_wb  (rdst_wb),
    .haz_a    (haz_a),
    .haz_b    (haz_b),
    .fwd_a    (fwd_a),
    .fwd_b    (fwd_b)
  );

  assign stall   = !FWD_EN && (haz_a || haz_b);
  assign halt_id = id_valid_q && (func_id == FN_HALT);

  always_comb begin
    state_d    = state_q;
    id_valid_d = id_valid_q;
    wb_valid_d = wb_valid_q;
    wb_wr_d    = wb_wr_q;
    wb_alu_d   = wb_alu_q;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idwb_en    = 1'b0;
    ret_n      = 2'd0;
    if (!hold) begin
      ret_n = {1'b0, wb_valid_q};
      unique case (state_q)
        ST_IDLE, ST_HALT: begin
          if (start) state_d = ST_FILL;
        end
        ST_FILL: begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          idwb_en    = 1'b1;
          wb_valid_d = 1'b0;
          wb_wr_d    = 1'b0;
          wb_alu_d   = ALU_IMM;
          id_valid_d = 1'b1;
          state_d    = ST_RUN;
        end
        ST_RUN: begin
          idwb_en = 1'b1;
          if (halt_id || stall) begin
            wb_valid_d = 1'b0;
            wb_wr_d    = 1'b0;
            wb_alu_d   = ALU_IMM;
            if (halt_id) begin
              // the HALT retires alongside whatever leaves WB
              ret_n      = ret_n + 2'd1;
              id_valid_d = 1'b0;
              state_d    = ST_HALT;
            end
          end else begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            wb_valid_d = id_valid_q;
            wb_wr_d    = id_valid_q & fn_writes(func_id);
            wb_alu_d   = (func_id == FN_ADD) ? ALU_ADD : ALU_IMM;
          end
        end
      endcase
    end
    retire_d = retire_q + RCNT_W'(ret_n);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      id_valid_q <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_wr_q    <= 1'b0;
      wb_alu_q   <= ALU_IMM;
      retire_q   <= '0;
    end else begin
      state_q    <= state_d;
      id_valid_q <= id_valid_d;
      wb_valid_q <= wb_valid_d;
      wb_wr_q    <= wb_wr_d;
      wb_alu_q   <= wb_alu_d;
      retire_q   <= retire_d;
    end
  end

  assign write       = wb_valid_q & wb_wr_q & ~hold;
  assign alu_control = wb_alu_q;
  assign halted      = (state_q == ST_HALT);
  assign retire_cnt  = retire_q;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench: forwarding and stalling sequencers driven side by side
// from a small fetch/regfile model, plus a 2-bit counter copy for wrap.
module tb_pipe_sequencer;
  import pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, hold;
  logic [1:0]  func_id [2];
  logic [2:0]  rdst_id [2];
  logic [2:0]  rsrc_id [2];
  logic [2:0]  rdst_wb [2];
  logic        pc_en [2];
  logic        ifid_en [2];
  logic        idwb_en [2];
  logic        alu_c [2];
  logic        wr [2];
  logic        fwd_a [2];
  logic        fwd_b [2];
  logic        halted [2];
  logic [15:0] rcnt [2];

  logic w_pc, w_ifid, w_idwb, w_alu, w_wr, w_fa, w_fb, w_halt;
  logic [1:0] w_rcnt;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipe_sequencer #(
      .RCNT_W (16),
      .FWD_EN (g == 0)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .hold        (hold),
      .func_id     (func_id[g]),
      .rdst_id     (rdst_id[g]),
      .rsrc_id     (rsrc_id[g]),
      .rdst_wb     (rdst_wb[g]),
      .pc_en       (pc_en[g]),
      .ifid_en     (ifid_en[g]),
      .idwb_en     (idwb_en[g]),
      .alu_control (alu_c[g]),
      .write       (wr[g]),
      .fwd_a       (fwd_a[g]),
      .fwd_b       (fwd_b[g]),
      .halted      (halted[g]),
      .retire_cnt  (rcnt[g])
    );
  end

  pipe_sequencer #(
    .RCNT_W (2),
    .FWD_EN (1'b1)
  ) u_wrap (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .hold        (hold),
    .func_id     (func_id[0]),
    .rdst_id     (rdst_id[0]),
    .rsrc_id     (rsrc_id[0]),
    .rdst_wb     (rdst_wb[0]),
    .pc_en       (w_pc),
    .ifid_en     (w_ifid),
    .idwb_en     (w_idwb),
    .alu_control (w_alu),
    .write       (w_wr),
    .fwd_a       (w_fa),
    .fwd_b       (w_fb),
    .halted      (w_halt),
    .retire_cnt  (w_rcnt)
  );

  logic [1:0] p_fn [16];
  logic [2:0] p_rd [16];
  logic [2:0] p_rs [16];
  int         pc [2];
  logic [7:0] rf [2][8];
  logic [7:0] wb_a [2];
  logic [7:0] wb_b [2];
  logic [7:0] wb_imm [2];

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic cpc [2];
    logic cif [2];
    logic cwb [2];
    logic cw [2];
    logic calu [2];
    logic cfa [2];
    logic cfb [2];
    logic [7:0] wd, oa, ob;
    #1;
    for (int k = 0; k < 2; k++) begin
      cpc[k] = pc_en[k];
      cif[k] = ifid_en[k];
      cwb[k] = idwb_en[k];
      cw[k] = wr[k];
      calu[k] = alu_c[k];
      cfa[k] = fwd_a[k];
      cfb[k] = fwd_b[k];
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      wd = calu[k] ? wb_a[k] + wb_b[k] : wb_imm[k];
      oa = cfa[k] ? wd : rf[k][rdst_id[k]];
      ob = cfb[k] ? wd : rf[k][rsrc_id[k]];
      if (cw[k]) rf[k][rdst_wb[k]] = wd;
      if (cwb[k]) begin
        wb_a[k] = oa;
        wb_b[k] = ob;
        wb_imm[k] = {5'd0, rsrc_id[k]};
        rdst_wb[k] = rdst_id[k];
      end
      if (cif[k]) begin
        func_id[k] = p_fn[pc[k]];
        rdst_id[k] = p_rd[pc[k]];
        rsrc_id[k] = p_rs[pc[k]];
      end
      if (cpc[k]) pc[k] = pc[k] + 1;
      if (!reset) pc[k] = 0;
    end
    @(negedge clk);
  endtask

  task automatic put(
    input int i, input logic [1:0] f,
    input logic [2:0] d, input logic [2:0] s
  );
    p_fn[i] = f;
    p_rd[i] = d;
    p_rs[i] = s;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    hold = 1'b0;
    for (int i = 0; i < 16; i++) put(i, FN_NOP, 3'd0, 3'd0);
    put(0, FN_LI, 3'd1, 3'd4);
    put(1, FN_LI, 3'd2, 3'd3);
    put(2, FN_HALT, 3'd0, 3'd0);
    put(3, FN_LI, 3'd1, 3'd5);
    put(4, FN_ADD, 3'd1, 3'd1);
    put(6, FN_HALT, 3'd0, 3'd0);
    put(7, FN_LI, 3'd3, 3'd6);
    for (int k = 0; k < 2; k++) begin
      pc[k] = 0;
      func_id[k] = 2'd0;
      rdst_id[k] = 3'd0;
      rsrc_id[k] = 3'd0;
      rdst_wb[k] = 3'd0;
      wb_a[k] = 8'd0;
      wb_b[k] = 8'd0;
      wb_imm[k] = 8'd0;
      for (int r = 0; r < 8; r++) rf[k][r] = 8'd0;
    end

    @(negedge clk);
    check("rst_pc_en", 32'(pc_en[0]), 0);
    check("rst_idwb", 32'(idwb_en[1]), 0);
    check("rst_write", 32'(wr[0]), 0);
    check("rst_halted", 32'(halted[0]), 0);
    check("rst_rcnt", 32'(rcnt[0]), 0);
    check("rst_fwd", 32'(fwd_a[0]), 0);
    reset = 1'b1;
    tick();
    check("idle_pc_en", 32'(pc_en[0]), 0);
    start = 1'b1;
    #1;
    check("idle_start_pc", 32'(pc_en[0]), 0);
    tick();
    start = 1'b0;
    #1;
    check("fill_pc_en", 32'(pc_en[0]), 1);
    check("fill_ifid", 32'(ifid_en[0]), 1);
    check("fill_idwb", 32'(idwb_en[0]), 1);
    check("fill_write", 32'(wr[0]), 0);
    tick();
    check("run1_write", 32'(wr[0]), 0);
    tick();
    check("li1_write", 32'(wr[0]), 1);
    check("li1_alu", 32'(alu_c[0]), 0);
    tick();
    check("li2_write", 32'(wr[0]), 1);
    check("halt_id_pc", 32'(pc_en[0]), 0);
    check("halt_id_ifid", 32'(ifid_en[0]), 0);
    tick();
    check("halted0", 32'(halted[0]), 1);
    check("halted1", 32'(halted[1]), 1);
    check("halt_rcnt0", 32'(rcnt[0]), 3);
    check("halt_rcnt1", 32'(rcnt[1]), 3);
    check("halt_wrap", 32'(w_rcnt), 3);
    check("halt_write", 32'(wr[0]), 0);
    check("rf_r1", 32'(rf[0][1]), 4);
    check("rf_r2", 32'(rf[0][2]), 3);
    tick();
    check("halt_pc_stay", 32'(pc_en[0]), 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check("resume_fill_pc", 32'(pc_en[0]), 1);
    check("resume_halted", 32'(halted[0]), 0);
    tick();
    check("r2_fwd_a", 32'(fwd_a[0]), 0);
    tick();
    check("fwd_a", 32'(fwd_a[0]), 1);
    check("fwd_b", 32'(fwd_b[0]), 1);
    check("fwd_nostall", 32'(pc_en[0]), 1);
    check("fwd_li_write", 32'(wr[0]), 1);
    check("stall_fwd_a", 32'(fwd_a[1]), 0);
    check("stall_pc", 32'(pc_en[1]), 0);
    check("stall_ifid", 32'(ifid_en[1]), 0);
    check("stall_li_write", 32'(wr[1]), 1);
    tick();
    check("add_write", 32'(wr[0]), 1);
    check("add_alu", 32'(alu_c[0]), 1);
    check("rcnt_after_li", 32'(rcnt[0]), 4);
    check("wrap_zero", 32'(w_rcnt), 0);
    check("bubble_pc", 32'(pc_en[1]), 1);
    check("bubble_write", 32'(wr[1]), 0);
    check("stall_rf_r1", 32'(rf[1][1]), 5);

    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_write", 32'(wr[0]), 0);
      check("hold_pc", 32'(pc_en[0]), 0);
      check("hold_idwb", 32'(idwb_en[0]), 0);
      check("hold_rcnt", 32'(rcnt[0]), 4);
      tick();
    end
    hold = 1'b0;
    #1;
    check("rel_write", 32'(wr[0]), 1);
    check("rel_alu", 32'(alu_c[0]), 1);
    check("rel_stall_write", 32'(wr[1]), 0);
    tick();
    check("rel_rcnt", 32'(rcnt[0]), 5);
    check("fwd_r1", 32'(rf[0][1]), 10);
    check("halt2_pc", 32'(pc_en[0]), 0);
    check("stall_add_write", 32'(wr[1]), 1);
    check("stall_add_alu", 32'(alu_c[1]), 1);
    tick();
    check("halt2_halted", 32'(halted[0]), 1);
    check("halt2_rcnt", 32'(rcnt[0]), 7);
    check("halt2_wrap", 32'(w_rcnt), 3);
    check("stall_r1", 32'(rf[1][1]), 10);
    check("stall_halted_late", 32'(halted[1]), 0);
    tick();
    check("stall_halted", 32'(halted[1]), 1);
    check("stall_rcnt", 32'(rcnt[1]), 7);

    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre_rst_write", 32'(wr[0]), 1);
    check("pre_rst_alu", 32'(alu_c[0]), 0);
    reset = 1'b0;
    #1;
    check("mid_rst_write0", 32'(wr[0]), 0);
    check("mid_rst_write1", 32'(wr[1]), 0);
    check("mid_rst_rcnt", 32'(rcnt[0]), 0);
    check("mid_rst_wrap", 32'(w_rcnt), 0);
    check("mid_rst_pc", 32'(pc_en[0]), 0);
    tick();
    reset = 1'b1;
    #1;
    check("rst_no_r3", 32'(rf[0][3]), 0);
    tick();
    check("post_rst_idle", 32'(pc_en[0]), 0);
    check("post_rst_halted", 32'(halted[0]), 0);
    start = 1'b1;
    hold = 1'b1;
    tick();
    start = 1'b0;
    hold = 1'b0;
    #1;
    check("hold_over_start", 32'(pc_en[0]), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check("restart_fill", 32'(pc_en[0]), 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
